// File: rtl/memchk_pkg.sv
// Shared constants and helpers for the mem_checker_p memory checker.
// The read-pipeline entry struct depends on the checker's DATA_W and
// ADDR_W, so the checker declares it from its own localparams.
package memchk_pkg;

   // Deepest read latency the checker is built to track.
   localparam int RD_LAT_MAX = 8;

   // Increment that stops at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
      logic [63:0] top;
      top = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      return (v >= top) ? top : v + 64'd1;
   endfunction

endpackage

// File: rtl/mem_checker_p_if.sv
// Memory pin bundle snooped by mem_checker_p.
// The memory/bench side drives it (master); the checker only observes it (slave).
interface mem_checker_p_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
) ();
   logic              cen;
   logic              rd;
   logic              wr;
   logic [ADDR_W-1:0] add;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;

   modport master (output cen, rd, wr, add, din, dout);
   modport slave  (input  cen, rd, wr, add, din, dout);
endinterface

// File: rtl/memchk_rd_pipe.sv
// Fixed-depth shift pipeline carrying in-flight read expectations.
// The MSB of each word is its valid flag; only that bit is cleared by
// reset or flush, the payload bits just shift along.
module memchk_rd_pipe
   import memchk_pkg::*;
#(
   parameter int W      = 8,
   parameter int STAGES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [W-1:0] in_word,
   output logic [W-1:0] out_word
);
   logic [STAGES-1:0]        vld_p;
   logic [STAGES-1:0][W-2:0] data_p;

   // Valid flags shift one stage per cycle and drop out on reset or flush.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_word[W-1];
         for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Payload shifts unconditionally; it is meaningless without its valid flag.
   always_ff @(posedge clk) begin
      data_p[0] <= in_word[W-2:0];
      for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
   end

   assign out_word = {vld_p[STAGES-1], data_p[STAGES-1]};

endmodule

// File: rtl/mem_checker_p.sv
// Passive checker for a single-port synchronous memory with chip enable.
// Shadows every accepted write, snapshots the expected data at each read
// accept and compares it with dout RD_LAT cycles later.
// Optional build macro MEMCHK_PWR_EN adds vdd/vss inputs and a pwr_err pulse;
// while power is not good no access is applied or tracked.
module mem_checker_p
   import memchk_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef MEMCHK_PWR_EN
   input  logic              vdd,
   input  logic              vss,
   output logic              pwr_err,
`endif
   mem_checker_p_if.slave    bus,
   output logic              err,
   output logic              err_sticky,
   output logic              proto_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  uninit_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_exp,
   output logic [DATA_W-1:0] first_obs
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int EW    = 1 + ADDR_W + DATA_W + 1;

   // valid must stay the MSB: the pipe treats its top bit as the valid flag.
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] exp;
      logic              known;
   } rd_entry_t;

   logic              pwr_good;
   logic              acc_wr;
   logic              acc_rd;
   logic              acc_both;
   logic              flush;
   logic              cmp_go;
   logic              uninit_go;
   logic              mismatch;
   logic [DATA_W-1:0] model [DEPTH];
   logic [DEPTH-1:0]  written;
   rd_entry_t         push_e;
   rd_entry_t         ret_e;

`ifdef MEMCHK_PWR_EN
   assign pwr_good = vdd & ~vss;
`else
   assign pwr_good = 1'b1;
`endif

   // A combined rd+wr still writes the model; it just never tracks a read.
   assign acc_wr   = bus.cen & bus.wr & pwr_good;
   assign acc_rd   = bus.cen & bus.rd & ~bus.wr & pwr_good;
   assign acc_both = bus.cen & bus.rd & bus.wr & pwr_good;
   assign flush    = ~pwr_good;

   // Expected value and written flag are snapshotted at accept time.
   always_comb begin
      push_e       = '0;
      push_e.valid = acc_rd;
      push_e.addr  = bus.add;
      push_e.exp   = model[bus.add];
      push_e.known = written[bus.add];
   end

   memchk_rd_pipe #(
      .W      (EW),
      .STAGES (RD_LAT)
   ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_word  (push_e),
      .out_word (ret_e)
   );

   // --- retire stage: entry leaving the pipe meets dout on this edge ---
   assign uninit_go = ret_e.valid & ~ret_e.known & pwr_good;
   assign cmp_go    = ret_e.valid &  ret_e.known & pwr_good;
   // Case inequality so an X/Z on dout is reported as a mismatch.
   assign mismatch  = cmp_go & (bus.dout !== ret_e.exp);

   // Shadow data store; contents are irrelevant until the bitmap marks them.
   always_ff @(posedge clk) begin
      if (!rst && acc_wr) model[bus.add] <= bus.din;
   end

   // Written bitmap, wiped on reset and for as long as power is bad.
   always_ff @(posedge clk) begin
      if (rst || !pwr_good) written <= '0;
      else if (acc_wr)      written[bus.add] <= 1'b1;
   end

   // Error pulses, saturating counters and first-mismatch capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         err            <= 1'b0;
         err_sticky     <= 1'b0;
         proto_err      <= 1'b0;
         err_cnt        <= '0;
         rd_cnt         <= '0;
         wr_cnt         <= '0;
         uninit_cnt     <= '0;
         first_err_addr <= '0;
         first_exp      <= '0;
         first_obs      <= '0;
      end else begin
         err       <= mismatch;
         proto_err <= acc_both;
         if (acc_wr)    wr_cnt     <= CNT_W'(sat_inc(64'(wr_cnt), CNT_W));
         if (cmp_go)    rd_cnt     <= CNT_W'(sat_inc(64'(rd_cnt), CNT_W));
         if (uninit_go) uninit_cnt <= CNT_W'(sat_inc(64'(uninit_cnt), CNT_W));
         if (mismatch)  err_cnt    <= CNT_W'(sat_inc(64'(err_cnt), CNT_W));
         if (mismatch && !err_sticky) begin
            err_sticky     <= 1'b1;
            first_err_addr <= ret_e.addr;
            first_exp      <= ret_e.exp;
            first_obs      <= bus.dout;
         end
      end
   end

`ifdef MEMCHK_PWR_EN
   // Flags any access attempted while the supply is not good.
   always_ff @(posedge clk) begin
      if (rst) pwr_err <= 1'b0;
      else     pwr_err <= ~pwr_good & bus.cen & (bus.rd | bus.wr);
   end
`endif

endmodule

// File: tb/tb_mem_checker_p.sv
// Bench for mem_checker_p: instance A (RD_LAT=1, 16-bit counters) and
// instance B (RD_LAT=3, 2-bit counters so saturation is reachable).
// A queue-based reference model is compared every cycle, plus literal checks.
module tb_mem_checker_p;
   localparam int DW    = 8;
   localparam int AW    = 12;
   localparam int DEPTH = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   mem_checker_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
   mem_checker_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

   logic          a_err, a_sticky, a_proto;
   logic [15:0]   a_errc, a_rdc, a_wrc, a_unc;
   logic [AW-1:0] a_faddr;
   logic [DW-1:0] a_fexp, a_fobs;
   logic          b_err, b_sticky, b_proto;
   logic [1:0]    b_errc, b_rdc, b_wrc, b_unc;
   logic [AW-1:0] b_faddr;
   logic [DW-1:0] b_fexp, b_fobs;
`ifdef MEMCHK_PWR_EN
   logic vdd, vss, a_pwr, b_pwr;
`endif

   mem_checker_p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst_a),
`ifdef MEMCHK_PWR_EN
      .vdd(vdd), .vss(vss), .pwr_err(a_pwr),
`endif
      .bus(bus_a), .err(a_err), .err_sticky(a_sticky), .proto_err(a_proto),
      .err_cnt(a_errc), .rd_cnt(a_rdc), .wr_cnt(a_wrc), .uninit_cnt(a_unc),
      .first_err_addr(a_faddr), .first_exp(a_fexp), .first_obs(a_fobs));

   mem_checker_p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst_b),
`ifdef MEMCHK_PWR_EN
      .vdd(vdd), .vss(vss), .pwr_err(b_pwr),
`endif
      .bus(bus_b), .err(b_err), .err_sticky(b_sticky), .proto_err(b_proto),
      .err_cnt(b_errc), .rd_cnt(b_rdc), .wr_cnt(b_wrc), .uninit_cnt(b_unc),
      .first_err_addr(b_faddr), .first_exp(b_fexp), .first_obs(b_fobs));

   // ---------------- reference model ----------------
   typedef struct {
      int            inst;
      int            due;
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
      bit            known;
   } pend_t;

   pend_t         pq[$];
   logic [DW-1:0] m_mem [2][DEPTH];
   bit            m_bm  [2][DEPTH];
   int unsigned   m_errc[2], m_rdc[2], m_wrc[2], m_unc[2];
   bit            m_err[2], m_sticky[2], m_proto[2], m_pwr[2];
   logic [AW-1:0] m_faddr[2];
   logic [DW-1:0] m_fexp[2], m_fobs[2];
   int            lat[2]  = '{1, 3};
   int unsigned   cmax[2] = '{65535, 3};
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;

   function automatic int unsigned sat(int unsigned v, int unsigned mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic drop_inst(int i);
      for (int k = pq.size() - 1; k >= 0; k--) if (pq[k].inst == i) pq.delete(k);
      for (int k = 0; k < DEPTH; k++) m_bm[i][k] = 1'b0;
   endtask

   task automatic mstep(int i, logic r, bit pg, logic cen, logic rd, logic wr,
                        logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] q);
      m_err[i] = 0; m_proto[i] = 0; m_pwr[i] = 0;
      if (r) begin
         drop_inst(i);
         m_errc[i] = 0; m_rdc[i] = 0; m_wrc[i] = 0; m_unc[i] = 0;
         m_sticky[i] = 0; m_faddr[i] = '0; m_fexp[i] = '0; m_fobs[i] = '0;
      end else if (!pg) begin
         drop_inst(i);
         if (cen && (rd || wr)) m_pwr[i] = 1;
      end else begin
         for (int k = 0; k < pq.size(); k++) begin
            if (pq[k].inst == i && pq[k].due == cyc) begin
               pend_t e;
               e = pq[k];
               pq.delete(k);
               if (!e.known) m_unc[i] = sat(m_unc[i], cmax[i]);
               else begin
                  m_rdc[i] = sat(m_rdc[i], cmax[i]);
                  if (q !== e.exp) begin
                     m_err[i]  = 1;
                     m_errc[i] = sat(m_errc[i], cmax[i]);
                     if (!m_sticky[i]) begin
                        m_sticky[i] = 1; m_faddr[i] = e.addr; m_fexp[i] = e.exp; m_fobs[i] = q;
                     end
                  end
               end
               break;
            end
         end
         if (cen && wr) begin
            m_mem[i][a] = d; m_bm[i][a] = 1; m_wrc[i] = sat(m_wrc[i], cmax[i]);
            if (rd) m_proto[i] = 1;
         end else if (cen && rd) begin
            pq.push_back('{i, cyc + lat[i], a, m_mem[i][a], m_bm[i][a]});
         end
      end
   endtask

   bit pg;
`ifdef MEMCHK_PWR_EN
   assign pg = (vdd === 1'b1) && (vss === 1'b0);
`else
   assign pg = 1'b1;
`endif

   always @(posedge clk) begin
      cyc++;
      mstep(0, rst_a, pg, bus_a.cen, bus_a.rd, bus_a.wr, bus_a.add, bus_a.din, bus_a.dout);
      mstep(1, rst_b, pg, bus_b.cen, bus_b.rd, bus_b.wr, bus_b.add, bus_b.din, bus_b.dout);
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Continuous comparison of every checker output against the model.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         chk("a.err", a_err, m_err[0]);       chk("a.err_sticky", a_sticky, m_sticky[0]);
         chk("a.proto_err", a_proto, m_proto[0]);
         chk("a.err_cnt", a_errc, m_errc[0]); chk("a.rd_cnt", a_rdc, m_rdc[0]);
         chk("a.wr_cnt", a_wrc, m_wrc[0]);    chk("a.uninit_cnt", a_unc, m_unc[0]);
         chk("a.first_err_addr", a_faddr, m_faddr[0]);
         chk("a.first_exp", a_fexp, m_fexp[0]); chk("a.first_obs", a_fobs, m_fobs[0]);
         chk("b.err", b_err, m_err[1]);       chk("b.err_sticky", b_sticky, m_sticky[1]);
         chk("b.proto_err", b_proto, m_proto[1]);
         chk("b.err_cnt", b_errc, m_errc[1]); chk("b.rd_cnt", b_rdc, m_rdc[1]);
         chk("b.wr_cnt", b_wrc, m_wrc[1]);    chk("b.uninit_cnt", b_unc, m_unc[1]);
         chk("b.first_err_addr", b_faddr, m_faddr[1]);
         chk("b.first_exp", b_fexp, m_fexp[1]); chk("b.first_obs", b_fobs, m_fobs[1]);
`ifdef MEMCHK_PWR_EN
         chk("a.pwr_err", a_pwr, m_pwr[0]);   chk("b.pwr_err", b_pwr, m_pwr[1]);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(int i, logic c, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
      if (i == 0) begin
         bus_a.cen = c; bus_a.rd = r; bus_a.wr = w; bus_a.add = a; bus_a.din = d;
      end else begin
         bus_b.cen = c; bus_b.rd = r; bus_b.wr = w; bus_b.add = a; bus_b.din = d;
      end
   endtask

   task automatic setq(int i, logic [DW-1:0] q);
      if (i == 0) bus_a.dout = q;
      else        bus_b.dout = q;
   endtask

   task automatic idle(int i);
      put(i, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic wr_op(int i, logic [AW-1:0] a, logic [DW-1:0] d);
      put(i, 1'b1, 1'b0, 1'b1, a, d); tick(); idle(i);
   endtask

   task automatic rd_op(int i, logic [AW-1:0] a);
      put(i, 1'b1, 1'b1, 1'b0, a, '0); tick(); idle(i);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      idle(0); idle(1); setq(0, '0); setq(1, '0);
`ifdef MEMCHK_PWR_EN
      vdd = 1'b1; vss = 1'b0;
`endif
      tick(); tick();
      chk("lit.reset.a_err_cnt", a_errc, 0);
      chk("lit.reset.a_sticky", a_sticky, 0);
      chk("lit.reset.b_wr_cnt", b_wrc, 0);
      rst_a = 1'b0; rst_b = 1'b0;

      // Write/read address 0 with matching data.
      wr_op(0, 12'h000, 8'hA5); rd_op(0, 12'h000); setq(0, 8'hA5); tick();
      chk("lit.t1.rd_cnt", a_rdc, 1); chk("lit.t1.err", a_err, 0); chk("lit.t1.err_cnt", a_errc, 0);

      // Mismatch at the top address, then a second mismatch elsewhere.
      wr_op(0, 12'hFFF, 8'h3C); rd_op(0, 12'hFFF); setq(0, 8'h3D); tick();
      chk("lit.t2.err", a_err, 1); chk("lit.t2.sticky", a_sticky, 1);
      chk("lit.t2.faddr", a_faddr, 12'hFFF); chk("lit.t2.fexp", a_fexp, 8'h3C);
      chk("lit.t2.fobs", a_fobs, 8'h3D);
      setq(0, '0); tick();
      chk("lit.t2.err_pulse_end", a_err, 0);
      wr_op(0, 12'h010, 8'h01); rd_op(0, 12'h010); setq(0, 8'h02); tick();
      chk("lit.t2.err_cnt", a_errc, 2); chk("lit.t2.faddr_kept", a_faddr, 12'hFFF);
      chk("lit.t2.fobs_kept", a_fobs, 8'h3D);

      // Uninitialised read, then reset and a normal compare.
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      chk("lit.t3.rst_sticky", a_sticky, 0);
      rd_op(0, 12'h123); tick();
      chk("lit.t3.uninit", a_unc, 1); chk("lit.t3.rd_cnt", a_rdc, 0); chk("lit.t3.err", a_err, 0);
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      wr_op(0, 12'h123, 8'h77); rd_op(0, 12'h123); setq(0, 8'h77); tick();
      chk("lit.t3.rd_cnt2", a_rdc, 1); chk("lit.t3.uninit2", a_unc, 0);

      // Simultaneous rd+wr: protocol pulse, write applied, no read tracked.
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      put(0, 1'b1, 1'b1, 1'b1, 12'h040, 8'h11); tick(); idle(0);
      chk("lit.t4.proto", a_proto, 1); chk("lit.t4.wr_cnt", a_wrc, 1);
      tick();
      chk("lit.t4.proto_end", a_proto, 0); chk("lit.t4.rd_cnt", a_rdc, 0);
      rd_op(0, 12'h040); setq(0, 8'h11); tick();
      chk("lit.t4.rd_ok", a_rdc, 1); chk("lit.t4.no_err", a_errc, 0);
      rd_op(0, 12'h040); setq(0, 8'h00); tick();
      chk("lit.t4.fexp", a_fexp, 8'h11); chk("lit.t4.faddr", a_faddr, 12'h040);

      // Back-to-back reads, one retire per cycle.
      wr_op(0, 12'h200, 8'h01); wr_op(0, 12'h201, 8'h02);
      put(0, 1'b1, 1'b1, 1'b0, 12'h200, '0); tick();
      put(0, 1'b1, 1'b1, 1'b0, 12'h201, '0); setq(0, 8'h01); tick();
      idle(0); setq(0, 8'h02); tick();
      chk("lit.b2b.rd_cnt", a_rdc, 4); chk("lit.b2b.err_cnt", a_errc, 1);

      // cen low: everything ignored.
      put(0, 1'b0, 1'b1, 1'b1, 12'h300, 8'hFF); tick(); idle(0);
      chk("lit.cen0.proto", a_proto, 0); chk("lit.cen0.wr_cnt", a_wrc, 3);
      rd_op(0, 12'h300); tick();
      chk("lit.cen0.uninit", a_unc, 1);

      // RD_LAT=3: in-flight expectation survives a later write.
      wr_op(1, 12'h050, 8'h22); rd_op(1, 12'h050); wr_op(1, 12'h050, 8'h99);
      tick(); setq(1, 8'h22); tick();
      chk("lit.lat3.err", b_err, 0); chk("lit.lat3.rd_cnt", b_rdc, 1); chk("lit.lat3.wr_cnt", b_wrc, 2);

      // Reset during flight discards the read.
      rd_op(1, 12'h050); tick(); rst_b = 1'b1; tick(); rst_b = 1'b0; setq(1, 8'h00); tick(); tick();
      chk("lit.lat3.rst_rd", b_rdc, 0); chk("lit.lat3.rst_err", b_errc, 0);
      chk("lit.lat3.rst_sticky", b_sticky, 0);

      // Saturation of the 2-bit counters.
      for (int k = 0; k < 5; k++) wr_op(1, AW'(k), DW'(k + 1));
      chk("lit.sat.wr_cnt", b_wrc, 3);
      for (int k = 0; k < 4; k++) begin
         rd_op(1, AW'(k)); tick(); tick(); setq(1, 8'hEE); tick();
      end
      chk("lit.sat.err_cnt", b_errc, 3); chk("lit.sat.rd_cnt", b_rdc, 3);
      chk("lit.sat.faddr", b_faddr, 12'h000); chk("lit.sat.fexp", b_fexp, 8'h01);
      chk("lit.sat.fobs", b_fobs, 8'hEE);

`ifdef MEMCHK_PWR_EN
      // Access while power is bad is reported and not applied.
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      vdd = 1'b0; wr_op(0, 12'h001, 8'h55);
      chk("lit.pwr.pulse", a_pwr, 1); chk("lit.pwr.wr_cnt", a_wrc, 0);
      vdd = 1'b1; tick();
      rd_op(0, 12'h001); tick();
      chk("lit.pwr.uninit", a_unc, 1);
`endif

      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
